// File: rtl/gen_scheduler_pkg.sv
// Shared board/speed sizes and the scheduler state encoding.
package gen_scheduler_pkg;
  localparam int LOG_BOARD_SIZE = 4;
  localparam int LOG_MAX_SPEED  = 4;

  typedef enum logic [2:0] {
    IDLE,
    EDIT_RD,
    EDIT_WR,
    STEP_GO,
    STEP_WAIT
  } sched_state_t;
endpackage

// File: rtl/gen_scheduler_rate_accumulator.sv
// Phase accumulator: adds speed every cycle, carry-out is a one-cycle step tick.
module rate_accumulator
  import gen_scheduler_pkg::*;
#(
  parameter int ACC_WIDTH = 24
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [LOG_MAX_SPEED-1:0] speed_in,
  output logic                     tick_out
);
  localparam int SUM_W = ((ACC_WIDTH > LOG_MAX_SPEED) ? ACC_WIDTH : LOG_MAX_SPEED) + 1;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [SUM_W-1:0]     sum;

  // Any bit above the accumulator width counts as a carry, so narrow
  // accumulators with wide speeds still tick.
  always_comb begin
    sum      = SUM_W'(acc_q) + SUM_W'(speed_in);
    acc_d    = sum[ACC_WIDTH-1:0];
    tick_out = rst_in && (sum[SUM_W-1:ACC_WIDTH] != '0);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) acc_q <= '0;
    else         acc_q <= acc_d;
  end
endmodule

// File: rtl/gen_scheduler.sv
// Serialises life-engine steps and click edits on the shared board port.
// Optional GEN_SCHED_SINGLE_STEP_EN adds a step_in button that requests one step.
module gen_scheduler
  import gen_scheduler_pkg::*;
#(
  parameter int ACC_WIDTH = 24,
  parameter int GEN_WIDTH = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [LOG_MAX_SPEED-1:0]    speed_in,
  input  logic                        click_in,
  input  logic [LOG_BOARD_SIZE-1:0]   cursor_x_in,
  input  logic [LOG_BOARD_SIZE-1:0]   cursor_y_in,
`ifdef GEN_SCHED_SINGLE_STEP_EN
  input  logic                        step_in,
`endif
  output logic                        engine_start_out,
  input  logic                        engine_done_in,
  output logic [2*LOG_BOARD_SIZE-1:0] edit_addr_out,
  output logic                        edit_we_out,
  output logic                        edit_wdata_out,
  input  logic                        edit_rdata_in,
  output logic                        busy_out,
  output logic [GEN_WIDTH-1:0]        generation_out,
  output logic                        overrun_out
);
  localparam int AW = 2*LOG_BOARD_SIZE;

  sched_state_t         state_q, state_d;
  logic                 click_prev_q;
  logic                 edit_pend_q, edit_pend_d;
  logic                 step_pend_q, step_pend_d;
  logic                 overrun_q, overrun_d;
  logic [AW-1:0]        req_addr_q, req_addr_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [GEN_WIDTH-1:0] gen_q, gen_d;
  logic                 tick, step_req, click_edge;

  rate_accumulator #(.ACC_WIDTH(ACC_WIDTH)) u_rate (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .speed_in (speed_in),
    .tick_out (tick)
  );

`ifdef GEN_SCHED_SINGLE_STEP_EN
  logic step_prev_q;
  always_ff @(posedge clk_in) begin
    if (!rst_in) step_prev_q <= step_in;
    else         step_prev_q <= step_in;
  end
  assign step_req = tick | (step_in & ~step_prev_q);
`else
  assign step_req = tick;
`endif

  always_comb begin
    click_edge       = click_in & ~click_prev_q;
    state_d          = state_q;
    edit_pend_d      = edit_pend_q;
    step_pend_d      = step_pend_q;
    req_addr_d       = req_addr_q;
    addr_d           = addr_q;
    gen_d            = gen_q;
    overrun_d        = overrun_q | (step_req & step_pend_q);
    engine_start_out = 1'b0;
    edit_we_out      = 1'b0;
    edit_wdata_out   = 1'b0;
    case (state_q)
      IDLE: begin
        if (edit_pend_q) begin
          state_d = EDIT_RD;
          addr_d  = req_addr_q;
        end else if (step_pend_q) begin
          state_d = STEP_GO;
        end
      end
      EDIT_RD: begin
        edit_pend_d = 1'b0;
        state_d     = EDIT_WR;
      end
      EDIT_WR: begin
        edit_we_out    = 1'b1;
        edit_wdata_out = ~edit_rdata_in;
        state_d        = IDLE;
      end
      STEP_GO: begin
        engine_start_out = 1'b1;
        step_pend_d      = 1'b0;
        state_d          = STEP_WAIT;
      end
      STEP_WAIT: begin
        if (engine_done_in) begin
          gen_d   = gen_q + GEN_WIDTH'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // New requests are applied after consumption so a same-cycle arrival survives.
    if (click_edge && (!edit_pend_q || state_q == EDIT_RD)) begin
      edit_pend_d = 1'b1;
      req_addr_d  = {cursor_y_in, cursor_x_in};
    end
    if (step_req) step_pend_d = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      click_prev_q <= click_in;
      edit_pend_q  <= 1'b0;
      step_pend_q  <= 1'b0;
      overrun_q    <= 1'b0;
      req_addr_q   <= '0;
      addr_q       <= '0;
      gen_q        <= '0;
    end else begin
      state_q      <= state_d;
      click_prev_q <= click_in;
      edit_pend_q  <= edit_pend_d;
      step_pend_q  <= step_pend_d;
      overrun_q    <= overrun_d;
      req_addr_q   <= req_addr_d;
      addr_q       <= addr_d;
      gen_q        <= gen_d;
    end
  end

  assign busy_out       = (state_q != IDLE);
  assign edit_addr_out  = addr_q;
  assign generation_out = gen_q;
  assign overrun_out    = overrun_q;
endmodule

// File: tb/tb_gen_scheduler.sv
// Directed bench for gen_scheduler with a delay-programmable engine model.
module tb_gen_scheduler;
  import gen_scheduler_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic [LOG_MAX_SPEED-1:0]    spd = '0;
  logic                        click = 1'b0;
  logic [LOG_BOARD_SIZE-1:0]   cx = '0, cy = '0;
  logic                        done_f = 1'b0;
  logic                        rd_val = 1'b0;
  logic                        start, done, we, wdata, busy, ovr;
  logic [2*LOG_BOARD_SIZE-1:0] addr;
  logic [15:0]                 gen;

  int nchk = 0, nerr = 0;
  int cyc = 0, eng_cnt = 0, eng_delay = 3, nstart = 0;
  int st_cyc [64];

  gen_scheduler #(.ACC_WIDTH(4), .GEN_WIDTH(16)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .speed_in         (spd),
    .click_in         (click),
    .cursor_x_in      (cx),
    .cursor_y_in      (cy),
`ifdef GEN_SCHED_SINGLE_STEP_EN
    .step_in          (1'b0),
`endif
    .engine_start_out (start),
    .engine_done_in   (done),
    .edit_addr_out    (addr),
    .edit_we_out      (we),
    .edit_wdata_out   (wdata),
    .edit_rdata_in    (rd_val),
    .busy_out         (busy),
    .generation_out   (gen),
    .overrun_out      (ovr)
  );

  always #5 clk = ~clk;

  // Engine model: done pulses eng_delay cycles after the start cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) eng_cnt = 0;
    else if (start) begin
      eng_cnt = eng_delay + 1;
      st_cyc[nstart % 64] = cyc;
      nstart = nstart + 1;
    end else if (eng_cnt != 0) eng_cnt = eng_cnt - 1;
  end
  assign done = (eng_cnt == 1) || done_f;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; spd = '0; click = 1'b0; done_f = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  task automatic wait_start(input int max);
    int ok;
    ok = 0;
    for (int i = 0; i < max && ok == 0; i++) begin
      step(1);
      if (start) ok = 1;
    end
    chk("start_seen", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, c0, lat, nwe, we_off, st_off, we_addr, we_data, hold_addr, ovr_seen;

    // Reset state
    rst = 1'b0;
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_we", we, 0);
    chk("rst_gen", gen, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_addr", addr, 0);

    // speed 1, 4-bit acc: one start every 16 cycles
    eng_delay = 3;
    b = nstart;
    rst = 1'b1; spd = 4'd1;
    step(72);
    spd = 4'd0;
    step(4);
    chk("s1_starts", nstart - b, 4);
    chk("s1_span", st_cyc[(b+3)%64] - st_cyc[b%64], 48);
    chk("s1_gen", gen, 4);
    chk("s1_ovr", ovr, 0);

    // paused, then speed 4
    b = nstart;
    step(100);
    chk("pause_starts", nstart - b, 0);
    eng_delay = 1;
    b = nstart; c0 = cyc; spd = 4'd4;
    step(24);
    chk("s4_nstarts_ge4", (nstart - b) >= 4, 1);
    lat = st_cyc[b%64] - c0 - 1;
    chk("s4_first_lat_ok", (lat >= 2) && (lat <= 6), 1);
    chk("s4_gap1", st_cyc[(b+1)%64] - st_cyc[b%64], 4);
    chk("s4_gap2", st_cyc[(b+2)%64] - st_cyc[(b+1)%64], 4);
    chk("s4_gap3", st_cyc[(b+3)%64] - st_cyc[(b+2)%64], 4);

    // Edit: cursor (5,9), rdata 0 -> write 1 at edge+3
    do_reset();
    cx = 4'd5; cy = 4'd9; rd_val = 1'b0;
    step(2);
    click = 1'b1;
    step(1);
    chk("e1_n1_busy", busy, 0);
    step(1);
    chk("e1_n2_busy", busy, 1);
    chk("e1_n2_we", we, 0);
    chk("e1_n2_addr", addr, 8'h95);
    step(1);
    chk("e1_n3_we", we, 1);
    chk("e1_n3_wdata", wdata, 1);
    chk("e1_n3_addr", addr, 8'h95);
    click = 1'b0;
    step(1);
    chk("e1_n4_we", we, 0);
    chk("e1_n4_busy", busy, 0);

    // Edit: cursor (3,12), rdata 1 -> write 0
    rd_val = 1'b1; cx = 4'd3; cy = 4'd12;
    step(2);
    click = 1'b1;
    step(3);
    chk("e2_we", we, 1);
    chk("e2_wdata", wdata, 0);
    chk("e2_addr", addr, 8'hC3);
    click = 1'b0;
    step(3);
    chk("e2_addr_hold", addr, 8'hC3);
    chk("e2_idle", busy, 0);

    // Clicks during a slow step: edit waits for done, then runs before next start
    do_reset();
    rd_val = 1'b0; eng_delay = 40; spd = 4'd8;
    wait_start(20);
    nwe = 0; we_off = 0; st_off = 0; we_addr = 0; we_data = 0; hold_addr = 0;
    for (int i = 1; i <= 60; i++) begin
      step(1);
      if (i == 3) begin click = 1'b1; cx = 4'd2; cy = 4'd7; end
      if (i == 4) click = 1'b0;
      if (i == 6) begin click = 1'b1; cx = 4'd6; cy = 4'd6; end
      if (i == 7) click = 1'b0;
      if (i == 10) hold_addr = addr;
      if (we) begin
        nwe++;
        if (we_off == 0) begin we_off = i; we_addr = addr; we_data = wdata; end
      end
      if (start && st_off == 0) st_off = i;
    end
    chk("sw_addr_hold", hold_addr, 0);
    chk("sw_nwrites", nwe, 1);
    chk("sw_we_offset", we_off, 43);
    chk("sw_we_addr", we_addr, 8'h72);
    chk("sw_we_data", we_data, 1);
    chk("sw_next_start", st_off, 45);
    chk("sw_gen", gen, 1);

    // Overrun: carries arrive while a step is still pending
    do_reset();
    eng_delay = 20; spd = 4'd3;
    step(1);
    chk("ov_init", ovr, 0);
    step(40);
    chk("ov_set", ovr, 1);
    spd = 4'd0;
    step(30);
    chk("ov_sticky", ovr, 1);
    do_reset();
    step(1);
    chk("ov_cleared", ovr, 0);

    // Click held through reset produces no edit
    rst = 1'b0; click = 1'b1;
    step(3);
    rst = 1'b1;
    nwe = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (we || busy) nwe++;
    end
    chk("rst_click_no_edit", nwe, 0);
    click = 1'b0;
    step(2);

    // Reset during STEP_WAIT, then a stray done
    do_reset();
    eng_delay = 50; spd = 4'd8;
    wait_start(20);
    step(3);
    chk("rw_busy_before", busy, 1);
    spd = 4'd0; rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    done_f = 1'b1;
    step(1);
    done_f = 1'b0;
    ovr_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (busy || start) ovr_seen++;
    end
    chk("rw_gen", gen, 0);
    chk("rw_idle", ovr_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
